otter_regfile_sb: RTL and testbench
===================================

Name: otter_regfile_sb

Overview:
- Parametrised successor register file for the pipelined OTTER core: configurable data width, register count and read-port count.
- Writes occur on the rising edge, with optional same-cycle write-to-read bypass.
- A per-register pending-write scoreboard (saturating counters) tracks in-flight producers, so decode can detect RAW hazards and stall.
- Sits between decode (read and issue) and writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of 2; register 0 is hardwired to zero.
- NUM_READ, 2, number of independent combinational read ports.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears registers, counters and error flag.
- rd_addr  in  NUM_READ*AW  packed read addresses, AW = $clog2(NREGS); port i at [i*AW +: AW].
- rd_data  out  NUM_READ*XLEN  packed read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NUM_READ  port i source has an outstanding write (RAW hazard).
- issue_valid  in  1  decode issues an instruction writing issue_rd.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle when issue_valid&&issue_ready.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- wb_err  out  1  sticky: writeback to a register with zero pending count.

Behaviour:
- Reset (async, any time incl. mid-operation): RF[*]=0, cnt[*]=0, wb_err=0. Outputs after reset: rd_data=0 for all ports, rd_busy=0, issue_ready=1.
- Register 0:
  - Never written; cnt[0] is never incremented or decremented.
  - Reads always return 0 with rd_busy=0.
  - issue to rd 0 is always ready and is a no-op.
  - wb to 0 is ignored and does not set wb_err.
- Write: on rising edge, if wb_en && wb_addr!=0, RF[wb_addr] <= wb_data. Latency 1 cycle to storage.
- Read: combinational. rd_data[i] = RF[rd_addr[i]]; 0 for address 0. Bypass rules are under Optional Feature.
- Issue handshake:
  - issue_ready = (issue_rd==0) || (cnt[issue_rd] != 2^CNT_W-1). It is combinational from issue_rd and counter state only.
  - Accepted issue increments cnt[issue_rd] at the edge.
  - Issue while not ready: no state change; decode must hold.
- Writeback count: wb_en with wb_addr!=0:
  - If cnt[wb_addr]>0, decrement it.
  - If cnt[wb_addr]==0, the count stays 0, wb_err <= 1 (sticky until reset), and the data is still written.
- Simultaneous accepted issue and wb to the same register:
  - Count unchanged (+1 -1). Data written.
  - This is legal even at max count: ready is evaluated on the pre-edge count, so at max it is 0 and the issue is not accepted. Only the decrement applies.
- Simultaneous issue and wb to different registers: independent.
- rd_busy[i] = (rd_addr[i]!=0) && (effective count != 0). The effective count is defined under Optional Feature.
- Counter arithmetic is unsigned CNT_W bits and never wraps: increment is blocked by issue_ready, decrement is blocked at 0.

Optional Feature:
- Macro: OTTER_REGFILE_BYPASS_EN.
- Defined:
  - If wb_en && wb_addr==rd_addr[i] && wb_addr!=0, rd_data[i]=wb_data in the same cycle.
  - Effective count = cnt - (that wb hit ? 1 : 0), so the last pending write completing this cycle clears busy.
- Not defined:
  - rd_data always comes from storage; the new value is visible the cycle after the wb edge.
  - Effective count = cnt, so busy remains asserted during the wb cycle.

Decomposition:
- Package otter_rf_pkg holds:
  - default localparams XLEN_DEF=32, NREGS_DEF=32, CNT_W_DEF=2;
  - function clog2-based AW helper;
  - typedef for packed read address/data arrays.
- One natural sub-module: otter_rf_scoreboard. It holds the counter array, issue_ready, wb_err and effective-count busy logic. The top level holds the data array and read muxes/bypass.

Test Plan:
- Reset mid-stream: write x5=0xDEADBEEF, issue x7, assert reset → rd_data(x5)=0, rd_busy(x7)=0, issue_ready=1, wb_err=0.
- Issue x3, then rd_addr0=3 → rd_busy[0]=1. wb x3=0x1234:
  - BYPASS_EN defined: same cycle rd_data[0]=0x1234, rd_busy[0]=0.
  - BYPASS_EN not defined: busy=1 that cycle, 0x1234 and busy=0 next cycle.
- Saturation, CNT_W=2: issue x9 three times → issue_ready=0 for issue_rd=9. Issue+wb x9 same cycle → ready stays 0, count drops to 2, next cycle ready=1.
- Simultaneous accepted issue x4 and wb x4=0x55 at count 1 → count stays 1, rd_busy stays 1, RF[4]=0x55.
- wb x6=0xAA with cnt[6]=0 → wb_err=1 sticky, RF[6]=0xAA. wb x0=0xFF → rd_data(x0)=0, wb_err state unchanged by it.
- NUM_READ=3: ports read x1, x1, x0 after wb x1=0x77 → 0x77, 0x77, 0, all busy=0.

Source files
------------

// File: rtl/otter_rf_pkg.sv
// Shared defaults, address-width helper and packed port vector types for the
// OTTER register file with pending-write scoreboard.
package otter_rf_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int CNT_W_DEF    = 2;
    localparam int NUM_READ_DEF = 2;

    // Register address width; a single-register file still needs one bit.
    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEF = rf_aw(NREGS_DEF);

    typedef logic [NUM_READ_DEF*AW_DEF-1:0]   rd_addr_vec_t;
    typedef logic [NUM_READ_DEF*XLEN_DEF-1:0] rd_data_vec_t;

endpackage

// File: rtl/otter_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register counting
// in-flight producers. Drives issue back-pressure, per-port RAW busy and the
// sticky unexpected-writeback flag.
// Build option: OTTER_REGFILE_BYPASS_EN lets a same-cycle writeback retire
// its pending count for busy purposes.
module otter_rf_scoreboard
    import otter_rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_READ*AW-1:0] rd_addr,
    output logic [NUM_READ-1:0]    rd_busy,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic                   issue_ready,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    output logic                   wb_err
);

    logic [CNT_W-1:0] cnt [NREGS];
    logic             issue_acc;
    logic             wb_live;

    // Ready depends only on the pre-edge count, so a saturated register
    // refuses issue even when a writeback to it lands the same cycle.
    assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != '1);
    assign issue_acc   = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_live     = wb_en && (wb_addr != '0);

    // Counter update: accepted issue increments, writeback decrements unless
    // already zero; both together on one register cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (issue_acc && (issue_rd == AW'(r))) begin
                    if (!(wb_live && (wb_addr == AW'(r)) && (cnt[r] != '0)))
                        cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (wb_live && (wb_addr == AW'(r)) && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Sticky error: a writeback arrived for a register with nothing pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wb_err <= 1'b0;
        else if (wb_live && (cnt[wb_addr] == '0))
            wb_err <= 1'b1;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
        logic [AW-1:0]    a;
        logic [CNT_W-1:0] c;
        logic [CNT_W-1:0] eff;
        logic             hit;

        assign a = rd_addr[i*AW +: AW];
        assign c = cnt[a];
`ifdef OTTER_REGFILE_BYPASS_EN
        assign hit = wb_live && (wb_addr == a);
`else
        assign hit = 1'b0;
`endif
        assign eff        = (hit && (c != '0)) ? c - CNT_W'(1) : c;
        assign rd_busy[i] = (a != '0) && (eff != '0);
    end

endmodule

// File: rtl/otter_regfile_sb.sv
// OTTER register file with pending-write scoreboard. Holds the data array and
// combinational read muxes; hazard tracking lives in otter_rf_scoreboard.
// Build option: OTTER_REGFILE_BYPASS_EN forwards writeback data to matching
// read ports in the same cycle; otherwise reads see storage only.
module otter_regfile_sb
    import otter_rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NUM_READ = 2,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic                     issue_ready,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     wb_err
);

    logic [XLEN-1:0] rf [NREGS];

    // Storage write; register 0 is never written so it stays zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) rf[r] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
`ifdef OTTER_REGFILE_BYPASS_EN
        assign rd_data[i*XLEN +: XLEN] =
            (a == '0)                       ? '0      :
            (wb_en && (wb_addr == a))       ? wb_data :
                                              rf[a];
`else
        assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 : rf[a];
`endif
    end

    otter_rf_scoreboard #(
        .NREGS    (NREGS),
        .CNT_W    (CNT_W),
        .NUM_READ (NUM_READ)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_err      (wb_err)
    );

endmodule

// File: tb/tb_otter_regfile_sb.sv
// Directed bench for otter_regfile_sb with three read ports.
module tb_otter_regfile_sb;

    localparam int XLEN = 32;
    localparam int NR   = 3;
    localparam int AW   = 5;

    logic               clock;
    logic               reset;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic               issue_valid;
    logic [AW-1:0]      issue_rd;
    logic               issue_ready;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [XLEN-1:0]    wb_data;
    logic               wb_err;

    int checks = 0;
    int errors = 0;

    otter_regfile_sb #(.XLEN(XLEN), .NREGS(32), .NUM_READ(NR), .CNT_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_err      (wb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] rdd(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_en       = 1'b0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        idle();
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        issue_valid = 1'b1; issue_rd = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL reset_rd_busy got %b exp 000", rd_busy); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
        @(negedge clock); reset = 1'b0;
        tick();
        do_wb(5'd5, 32'hDEADBEEF);
        do_issue(5'd7);
        set_rd(0, 5'd5); set_rd(1, 5'd7); issue_rd = 5'd7;
        #1;
        checks++; if (rdd(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_x5 got %h exp deadbeef", rdd(0)); end
        checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy_x7 got %b exp 1", rd_busy[1]); end
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL pre_reset_wb_err got %b exp 1", wb_err); end
        #1 reset = 1'b1;
        #1;
        checks++; if (rdd(0) !== 32'h0) begin errors++; $display("FAIL midreset_x5 got %h exp 0", rdd(0)); end
        checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL midreset_busy_x7 got %b exp 0", rd_busy[1]); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", issue_ready); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL midreset_wb_err got %b exp 0", wb_err); end
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_raw_bypass();
        do_issue(5'd3);
        set_rd(0, 5'd3);
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL raw_busy got %b exp 1", rd_busy[0]); end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        #1;
`ifdef OTTER_REGFILE_BYPASS_EN
        checks++; if (rdd(0) !== 32'h1234) begin errors++; $display("FAIL raw_wbcycle_data got %h exp 1234", rdd(0)); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL raw_wbcycle_busy got %b exp 0", rd_busy[0]); end
`else
        checks++; if (rdd(0) !== 32'h0) begin errors++; $display("FAIL raw_wbcycle_data got %h exp 0", rdd(0)); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL raw_wbcycle_busy got %b exp 1", rd_busy[0]); end
`endif
        tick();
        idle();
        #1;
        checks++; if (rdd(0) !== 32'h1234) begin errors++; $display("FAIL raw_next_data got %h exp 1234", rdd(0)); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL raw_next_busy got %b exp 0", rd_busy[0]); end
    endtask

    task automatic test_saturation();
        issue_valid = 1'b1; issue_rd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_step%0d got %b exp 1", k, issue_ready); end
            tick();
        end
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full_ready got %b exp 0", issue_ready); end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_issue_wb_ready got %b exp 0", issue_ready); end
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_after_wb_ready got %b exp 1", issue_ready); end
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_cnt2_busy got %b exp 1", rd_busy[0]); end
        do_wb(5'd9, 32'h99);
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_cnt1_busy got %b exp 1", rd_busy[0]); end
        do_wb(5'd9, 32'h99);
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sat_cnt0_busy got %b exp 0", rd_busy[0]); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL sat_wb_err got %b exp 0", wb_err); end
    endtask

    task automatic test_same_reg();
        do_issue(5'd4);
        issue_valid = 1'b1; issue_rd = 5'd4;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", issue_ready); end
        tick();
        idle();
        set_rd(0, 5'd4);
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", rd_busy[0]); end
        checks++; if (rdd(0) !== 32'h55) begin errors++; $display("FAIL same_data got %h exp 55", rdd(0)); end
        do_wb(5'd4, 32'h56);
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL same_drain_busy got %b exp 0", rd_busy[0]); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL same_wb_err got %b exp 0", wb_err); end
    endtask

    task automatic test_multiport();
        do_issue(5'd1);
        do_wb(5'd1, 32'h77);
        set_rd(0, 5'd1); set_rd(1, 5'd1); set_rd(2, 5'd0);
        #1;
        checks++; if (rdd(0) !== 32'h77) begin errors++; $display("FAIL mp_port0 got %h exp 77", rdd(0)); end
        checks++; if (rdd(1) !== 32'h77) begin errors++; $display("FAIL mp_port1 got %h exp 77", rdd(1)); end
        checks++; if (rdd(2) !== 32'h0) begin errors++; $display("FAIL mp_port2 got %h exp 0", rdd(2)); end
        checks++; if (rd_busy !== 3'b000) begin errors++; $display("FAIL mp_busy got %b exp 000", rd_busy); end
        do_wb(5'd0, 32'hFF);
        #1;
        checks++; if (rdd(2) !== 32'h0) begin errors++; $display("FAIL mp_x0_after_wb got %h exp 0", rdd(2)); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL mp_x0_wb_err got %b exp 0", wb_err); end
    endtask

    task automatic test_wb_err();
        set_rd(0, 5'd6); set_rd(2, 5'd0);
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hAA;
        #1;
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", wb_err); end
        tick();
        idle();
        #1;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", wb_err); end
        checks++; if (rdd(0) !== 32'hAA) begin errors++; $display("FAIL err_data got %h exp aa", rdd(0)); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", rd_busy[0]); end
        do_wb(5'd0, 32'hFF);
        tick();
        tick();
        checks++; if (rdd(2) !== 32'h0) begin errors++; $display("FAIL err_x0_data got %h exp 0", rdd(2)); end
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", wb_err); end
    endtask

    initial begin
        reset       = 1'b1;
        rd_addr     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        test_reset();
        test_raw_bypass();
        test_saturation();
        test_same_reg();
        test_multiport();
        test_wb_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
